// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - write/commit/config and pin-drive bundle for seg_scan_ctrl
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8,
    parameter int DIM_W      = 3
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [7:0]            wr_data;
    logic                  commit;
    logic [NUM_DIGITS-1:0] blink_mask;
    logic [DIM_W-1:0]      brightness;
    logic [7:0]            seg_out;
    logic [NUM_DIGITS-1:0] seg_an;
    logic                  commit_pending;
    logic                  commit_ack;
    logic                  frame_done;

    modport master (
        output wr_en, wr_idx, wr_data, commit, blink_mask, brightness,
        input  seg_out, seg_an, commit_pending, commit_ack, frame_done
    );

    modport slave (
        input  wr_en, wr_idx, wr_data, commit, blink_mask, brightness,
        output seg_out, seg_an, commit_pending, commit_ack, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - double-buffered 7-seg scan controller with blink, PWM dim and commit ack
// Optional anti-ghost dead time at slot start: define SEG_SCAN_GHOST_BLANK_EN.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int SCAN_DIV_W  = 17,
    parameter int DIM_W       = 3,
    parameter int BLINK_DIV_W = 26
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_ctrl_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } commit_state_t;

    commit_state_t r_state;
    commit_state_t w_state_nxt;

    logic [SCAN_DIV_W-1:0]  r_slot_cnt;
    logic [IDX_W-1:0]       r_scan_idx;
    logic [BLINK_DIV_W-1:0] r_blink_cnt;
    logic                   r_blink_phase;
    logic [7:0]             r_shadow  [NUM_DIGITS];
    logic [7:0]             r_display [NUM_DIGITS];
    logic                   r_commit_ack;
    logic [NUM_DIGITS-1:0]  r_seg_an;
    logic [7:0]             r_seg_out;

    logic                   w_slot_wrap;
    logic                   w_boundary;
    logic                   w_apply;
    logic                   w_lit;
    logic                   w_blank;
    logic                   w_ghost;
    logic                   w_wr_ok;
    logic [NUM_DIGITS-1:0]  w_an_onehot;

    assign w_slot_wrap = &r_slot_cnt;
    assign w_boundary  = w_slot_wrap && (r_scan_idx == LAST_IDX);
    assign w_wr_ok     = bus.wr_en && (32'(bus.wr_idx) < NUM_DIGITS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt    <= '0;
            r_scan_idx    <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_slot_cnt  <= r_slot_cnt + 1'b1;
            r_blink_cnt <= r_blink_cnt + 1'b1;
            // Explicit wrap keeps non-power-of-2 digit counts inside the legal range
            if (w_slot_wrap) begin
                r_scan_idx <= (r_scan_idx == LAST_IDX) ? '0 : r_scan_idx + 1'b1;
            end
            if (&r_blink_cnt) begin
                r_blink_phase <= ~r_blink_phase;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A commit arriving while already pending is simply absorbed
    always_comb begin
        w_state_nxt = r_state;
        w_apply     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.commit) begin
                    w_state_nxt = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (w_boundary) begin
                    w_apply     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_shadow[i]  <= 8'h00;
                r_display[i] <= 8'h00;
            end
            r_commit_ack <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_shadow[bus.wr_idx] <= bus.wr_data;
            end
            // Copy samples the pre-edge shadow, so a same-cycle write misses it
            if (w_apply) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    r_display[i] <= r_shadow[i];
                end
            end
            r_commit_ack <= w_apply;
        end
    end

    assign w_lit       = r_slot_cnt[SCAN_DIV_W-1 -: DIM_W] <= bus.brightness;
    assign w_blank     = r_blink_phase && bus.blink_mask[r_scan_idx];
    assign w_an_onehot = NUM_DIGITS'(1) << r_scan_idx;

`ifdef SEG_SCAN_GHOST_BLANK_EN
    assign w_ghost = r_slot_cnt < SCAN_DIV_W'(16);
`else
    assign w_ghost = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_an  <= '0;
            r_seg_out <= 8'h00;
        end else if (w_lit && !w_blank && !w_ghost) begin
            r_seg_an  <= w_an_onehot;
            r_seg_out <= r_display[r_scan_idx];
        end else begin
            r_seg_an  <= '0;
            r_seg_out <= 8'h00;
        end
    end

    assign bus.seg_out        = r_seg_out;
    assign bus.seg_an         = r_seg_an;
    assign bus.commit_pending = (r_state == ST_PENDING);
    assign bus.commit_ack     = r_commit_ack;
    assign bus.frame_done     = w_boundary;
endmodule
